// File: rtl/mem_access_unit_if.sv
// Request/response and word-bus signal bundle for mem_access_unit.
// master = the access unit, slave = pipeline/bus side.
interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              flush;
  logic              stall;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              misaligned;
  logic              bus_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN/8-1:0] bus_wstrb;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    input  req_valid, req_we, req_type, req_addr, req_wdata, flush, bus_ack, bus_rdata,
    output stall, resp_valid, resp_rdata, misaligned, bus_err,
           bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

  modport slave (
    output req_valid, req_we, req_type, req_addr, req_wdata, flush, bus_ack, bus_rdata,
    input  stall, resp_valid, resp_rdata, misaligned, bus_err,
           bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage load/store engine on a valid/ack word bus.
// Optional MEM_TIMEOUT_EN: bounds WAIT/DRAIN to TIMEOUT cycles and reports bus_err.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.master mif
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  if (!(XLEN == 32 || XLEN == 64) || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
    $error("mem_access_unit: illegal XLEN or TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [NB-1:0]     bus_wstrb_q, bus_wstrb_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;
  logic [2:0]        type_q, type_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              timeout_hit;

  // Request decode: legality, alignment, strobes and lane-replicated data.
  logic [1:0]      sz;
  logic            illegal, unaligned;
  logic [2:0]      offmask;
  logic [7:0]      bmask;
  logic [NB-1:0]   smask, strb;
  logic [XLEN-1:0] rep;

  always_comb begin
    sz        = mif.req_type[1:0];
    illegal   = (mif.req_type == 3'b111) ||
                (XLEN == 32 && (mif.req_type == 3'b011 || mif.req_type == 3'b110));
    offmask   = 3'((4'd1 << sz) - 4'd1);
    unaligned = |(mif.req_addr[2:0] & offmask);
    case (sz)
      2'd0:    bmask = 8'h01;
      2'd1:    bmask = 8'h03;
      2'd2:    bmask = 8'h0F;
      default: bmask = 8'hFF;
    endcase
    smask = NB'(bmask);
    strb  = smask << mif.req_addr[LW-1:0];
    case (sz)
      2'd0:    rep = {NB{mif.req_wdata[7:0]}};
      2'd1:    rep = {(NB/2){mif.req_wdata[15:0]}};
      2'd2:    rep = {(NB/4){mif.req_wdata[31:0]}};
      default: rep = mif.req_wdata;
    endcase
  end

  // Load extract: shift the addressed bytes down, then extend via a left/right shift pair.
  logic [XLEN-1:0] sh, left, ld;
  logic [6:0]      amt;

  always_comb begin
    sh   = mif.bus_rdata >> {lane_q, 3'b000};
    amt  = 7'(XLEN) - (7'd8 << type_q[1:0]);
    left = sh << amt;
    ld   = type_q[2] ? (left >> amt) : XLEN'($signed(left) >>> amt);
  end

`ifdef MEM_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (state_q == WAIT || state_q == DRAIN) ? cnt_q + 16'd1 : 16'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign timeout_hit = (state_q == WAIT || state_q == DRAIN) && !mif.bus_ack &&
                       (cnt_q == 16'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_wdata_d  = bus_wdata_q;
    type_d       = type_q;
    lane_d       = lane_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    mis_d        = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: if (mif.req_valid && !mif.flush) begin
        if (illegal || unaligned) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          mis_d        = 1'b1;
        end else begin
          state_d     = WAIT;
          bus_req_d   = 1'b1;
          bus_we_d    = mif.req_we;
          bus_addr_d  = {mif.req_addr[ADDR_W-1:LW], {LW{1'b0}}};
          bus_wstrb_d = mif.req_we ? strb : '0;
          bus_wdata_d = mif.req_we ? rep : '0;
          type_d      = mif.req_type;
          lane_d      = mif.req_addr[LW-1:0];
        end
      end
      WAIT: begin
        if (mif.flush) begin
          // The bus cycle is already out; finish it silently.
          if (mif.bus_ack || timeout_hit) begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (mif.bus_ack) begin
          state_d      = DONE;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = bus_we_q ? '0 : ld;
        end else if (timeout_hit) begin
          state_d      = DONE;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          err_d        = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      DRAIN: if (mif.bus_ack || timeout_hit) begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wstrb_q  <= '0;
      bus_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mis_q        <= 1'b0;
      err_q        <= 1'b0;
      type_q       <= '0;
      lane_q       <= '0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mis_q        <= mis_d;
      err_q        <= err_d;
      type_q       <= type_d;
      lane_q       <= lane_d;
    end
  end

  assign mif.stall      = (mif.req_valid && !mif.flush && state_q != DONE) || state_q == DRAIN;
  assign mif.resp_valid = resp_valid_q;
  assign mif.resp_rdata = resp_rdata_q;
  assign mif.misaligned = mis_q;
  assign mif.bus_err    = err_q;
  assign mif.bus_req    = bus_req_q;
  assign mif.bus_we     = bus_we_q;
  assign mif.bus_addr   = bus_addr_q;
  assign mif.bus_wstrb  = bus_wstrb_q;
  assign mif.bus_wdata  = bus_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=32, TIMEOUT=4) against a byte-level reference model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) mif ();
  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .mif(mif));

  typedef struct {
    bit          saw;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wd;
    bit          changed;
    int          n_stall;
    int          n_breq;
    int          n_resp;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    bit          hung;
  } obs_t;

  // Reference model: byte-level view of the access rules.
  function automatic int sz_of(logic [2:0] t);
    return 1 << t[1:0];
  endfunction

  function automatic bit m_bad(logic [2:0] t, logic [31:0] a);
    return (t == 3'd7) || (t == 3'd3) || (t == 3'd6) || ((a % sz_of(t)) != 0);
  endfunction

  function automatic logic [3:0] m_strb(logic [2:0] t, logic [31:0] a);
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(a % 4) && i < int'(a % 4) + sz_of(t)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] t, logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz_of(t)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] t, logic [31:0] a, logic [31:0] rd);
    logic [31:0] v = '0;
    int sz = sz_of(t);
    for (int k = 0; k < sz; k++) v[8*k +: 8] = rd[8*(int'(a % 4) + k) +: 8];
    if (!t[2] && v[8*sz-1])
      for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // Drives one request, acks dly cycles after bus_req rises, records what was seen.
  task automatic run_txn(input bit we, input logic [2:0] t, input logic [31:0] a, wd, rd,
                         input int dly, input int tail, output obs_t o);
    int c = 0, rc = 0;
    bit fin = 0;
    o = '{default: '0};
    @(negedge clk);
    mif.req_valid = 1'b1; mif.req_we = we; mif.req_type = t;
    mif.req_addr = a; mif.req_wdata = wd; mif.flush = 1'b0;
    while (!fin && c < 300) begin
      #1;
      if (mif.stall) o.n_stall++;
      if (mif.bus_req) begin
        if (!o.saw) begin
          o.saw = 1; rc = c;
          o.addr = mif.bus_addr; o.we = mif.bus_we; o.strb = mif.bus_wstrb; o.wd = mif.bus_wdata;
        end else if (mif.bus_addr !== o.addr || mif.bus_we !== o.we ||
                     mif.bus_wstrb !== o.strb || mif.bus_wdata !== o.wd) o.changed = 1;
        o.n_breq++;
        if (c - rc == dly) begin mif.bus_ack = 1'b1; mif.bus_rdata = rd; end
      end
      if (mif.resp_valid) begin
        o.n_resp++; o.rdata = mif.resp_rdata; o.mis = mif.misaligned; o.err = mif.bus_err; fin = 1;
      end
      @(posedge clk); #1;
      mif.bus_ack = 1'b0;
      if (fin) mif.req_valid = 1'b0;
      else @(negedge clk);
      c++;
    end
    o.hung = !fin;
    mif.req_valid = 1'b0;
    repeat (tail) begin
      @(negedge clk); #1;
      if (mif.resp_valid) o.n_resp++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (mif.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req got=%b exp=0", mif.bus_req); end
    n_checks++; if (mif.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", mif.resp_valid); end
    n_checks++; if ({mif.bus_addr, mif.bus_wstrb, mif.bus_wdata} !== 68'd0) begin n_fail++; $display("FAIL reset_bus_fields got=%h exp=0", {mif.bus_addr, mif.bus_wstrb, mif.bus_wdata}); end
    n_checks++; if ({mif.resp_rdata, mif.misaligned, mif.bus_err, mif.bus_we} !== 35'd0) begin n_fail++; $display("FAIL reset_resp_fields got=%h exp=0", {mif.resp_rdata, mif.misaligned, mif.bus_err, mif.bus_we}); end
    n_checks++; if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", mif.stall); end
    rst = 1'b0;
    // Reset in the middle of a bus cycle.
    @(negedge clk);
    mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_type = 3'b010; mif.req_addr = 32'h40;
    @(posedge clk); @(negedge clk); #1;
    n_checks++; if (mif.bus_req !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_req got=%b exp=1", mif.bus_req); end
    #1 rst = 1'b1; mif.req_valid = 1'b0; #1;
    n_checks++; if (mif.bus_req !== 1'b0 || mif.stall !== 1'b0) begin n_fail++; $display("FAIL midrst_req got=%b/%b exp=0/0", mif.bus_req, mif.stall); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (mif.bus_req !== 1'b0 || mif.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after got=%b/%b exp=0/0", mif.bus_req, mif.resp_valid); end
  endtask

  task automatic test_lw;
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h8000_00FF, 3, 2, o);
    n_checks++; if (o.hung !== 1'b0 || o.n_resp !== 1) begin n_fail++; $display("FAIL lw_resp hung=%0d resp=%0d exp=0/1", o.hung, o.n_resp); end
    n_checks++; if (o.addr !== 32'h100 || o.strb !== 4'b0 || o.we !== 1'b0) begin n_fail++; $display("FAIL lw_bus addr=%h strb=%b we=%b exp=100/0000/0", o.addr, o.strb, o.we); end
    n_checks++; if (o.rdata !== 32'h8000_00FF) begin n_fail++; $display("FAIL lw_rdata got=%h exp=800000ff", o.rdata); end
    n_checks++; if (o.n_stall !== 5) begin n_fail++; $display("FAIL lw_stall got=%0d exp=5", o.n_stall); end
    n_checks++; if (o.changed !== 1'b0) begin n_fail++; $display("FAIL lw_bus_stable got=%0d exp=0", o.changed); end
  endtask

  task automatic test_sb;
    obs_t o;
    run_txn(1'b1, 3'b000, 32'h203, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 1, o);
    n_checks++; if (o.addr !== 32'h200 || o.strb !== 4'b1000 || o.we !== 1'b1) begin n_fail++; $display("FAIL sb_bus addr=%h strb=%b we=%b exp=200/1000/1", o.addr, o.strb, o.we); end
    n_checks++; if (o.wd !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata got=%h exp=abababab", o.wd); end
    n_checks++; if (o.rdata !== 32'h0 || o.n_resp !== 1) begin n_fail++; $display("FAIL sb_resp rdata=%h n=%0d exp=0/1", o.rdata, o.n_resp); end
  endtask

  task automatic test_lb_lbu;
    obs_t o;
    run_txn(1'b0, 3'b000, 32'h2, 32'h0, 32'h0080_0000, 0, 1, o);
    n_checks++; if (o.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata got=%h exp=ffffff80", o.rdata); end
    n_checks++; if (o.n_stall !== 2) begin n_fail++; $display("FAIL lb_stall got=%0d exp=2", o.n_stall); end
    run_txn(1'b0, 3'b100, 32'h2, 32'h0, 32'h0080_0000, 0, 1, o);
    n_checks++; if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata got=%h exp=00000080", o.rdata); end
  endtask

  task automatic test_misaligned;
    obs_t o;
    run_txn(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 2, o);
    n_checks++; if (o.saw !== 1'b0) begin n_fail++; $display("FAIL mis_no_bus got=%0d exp=0", o.saw); end
    n_checks++; if (o.mis !== 1'b1 || o.n_resp !== 1 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL mis_resp mis=%b n=%0d rd=%h exp=1/1/0", o.mis, o.n_resp, o.rdata); end
    n_checks++; if (o.n_stall !== 1) begin n_fail++; $display("FAIL mis_stall got=%0d exp=1", o.n_stall); end
    run_txn(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 1, o);
    n_checks++; if (o.saw !== 1'b0 || o.mis !== 1'b1) begin n_fail++; $display("FAIL illegal_ld saw=%0d mis=%b exp=0/1", o.saw, o.mis); end
  endtask

  task automatic test_timeout;
    obs_t o;
`ifdef MEM_TIMEOUT_EN
    run_txn(1'b0, 3'b010, 32'h80, 32'h0, 32'h1234_5678, 1000, 0, o);
    n_checks++; if (o.n_breq !== 4 || o.n_stall !== 5) begin n_fail++; $display("FAIL to_len breq=%0d stall=%0d exp=4/5", o.n_breq, o.n_stall); end
    n_checks++; if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.n_resp !== 1) begin n_fail++; $display("FAIL to_resp err=%b rd=%h n=%0d exp=1/0/1", o.err, o.rdata, o.n_resp); end
    @(negedge clk); mif.bus_ack = 1'b1; mif.bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 mif.bus_ack = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++; if (mif.resp_valid !== 1'b0 || mif.bus_req !== 1'b0) begin n_fail++; $display("FAIL to_late_ack rv=%b req=%b exp=0/0", mif.resp_valid, mif.bus_req); end
    end
`else
    run_txn(1'b0, 3'b010, 32'h80, 32'h0, 32'h1234_5678, 12, 1, o);
    n_checks++; if (o.n_breq !== 13 || o.n_stall !== 14) begin n_fail++; $display("FAIL long_len breq=%0d stall=%0d exp=13/14", o.n_breq, o.n_stall); end
    n_checks++; if (o.err !== 1'b0 || o.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL long_resp err=%b rd=%h exp=0/12345678", o.err, o.rdata); end
`endif
  endtask

  task automatic test_flush_drain;
    obs_t o;
    @(negedge clk);
    mif.req_valid = 1'b1; mif.req_we = 1'b1; mif.req_type = 3'b010;
    mif.req_addr = 32'h40; mif.req_wdata = 32'hDEAD_BEEF; mif.flush = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    n_checks++; if (mif.bus_req !== 1'b1) begin n_fail++; $display("FAIL fl_wait_req got=%b exp=1", mif.bus_req); end
    @(negedge clk); mif.flush = 1'b1;
    @(posedge clk); #1 mif.flush = 1'b0; mif.req_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (mif.stall !== 1'b1 || mif.bus_req !== 1'b1 || mif.resp_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drain1 st=%b req=%b rv=%b exp=1/1/0", mif.stall, mif.bus_req, mif.resp_valid); end
    @(negedge clk); #1;
    n_checks++; if (mif.stall !== 1'b1) begin n_fail++; $display("FAIL fl_drain2 st=%b exp=1", mif.stall); end
    mif.bus_ack = 1'b1;
    @(posedge clk); #1 mif.bus_ack = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++; if (mif.stall !== 1'b0 || mif.bus_req !== 1'b0 || mif.resp_valid !== 1'b0) begin n_fail++; $display("FAIL fl_after st=%b req=%b rv=%b exp=0/0/0", mif.stall, mif.bus_req, mif.resp_valid); end
    end
    // Flush and ack together in WAIT: silent return to IDLE.
    @(negedge clk);
    mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_type = 3'b010; mif.req_addr = 32'h44;
    @(posedge clk); @(negedge clk); mif.flush = 1'b1; mif.bus_ack = 1'b1;
    @(posedge clk); #1 mif.flush = 1'b0; mif.bus_ack = 1'b0; mif.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      n_checks++; if (mif.stall !== 1'b0 || mif.bus_req !== 1'b0 || mif.resp_valid !== 1'b0) begin n_fail++; $display("FAIL flack_after st=%b req=%b rv=%b exp=0/0/0", mif.stall, mif.bus_req, mif.resp_valid); end
    end
    run_txn(1'b0, 3'b101, 32'h46, 32'h0, 32'h8001_0000, 1, 1, o);
    n_checks++; if (o.rdata !== 32'h0000_8001 || o.n_resp !== 1) begin n_fail++; $display("FAIL fl_next rd=%h n=%0d exp=00008001/1", o.rdata, o.n_resp); end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    run_txn(1'b0, 3'b001, 32'h12, 32'h0, 32'h8765_0000, 0, 0, o);
    n_checks++; if (o.rdata !== 32'hFFFF_8765 || o.n_stall !== 2) begin n_fail++; $display("FAIL b2b_lh rd=%h st=%0d exp=ffff8765/2", o.rdata, o.n_stall); end
    run_txn(1'b1, 3'b001, 32'h16, 32'h0000_BEEF, 32'h0, 0, 0, o);
    n_checks++; if (o.strb !== 4'b1100 || o.wd !== 32'hBEEF_BEEF || o.n_stall !== 2) begin n_fail++; $display("FAIL b2b_sh strb=%b wd=%h st=%0d exp=1100/beefbeef/2", o.strb, o.wd, o.n_stall); end
    run_txn(1'b0, 3'b010, 32'h1C, 32'h0, 32'hCAFE_F00D, 0, 1, o);
    n_checks++; if (o.rdata !== 32'hCAFE_F00D || o.n_resp !== 1) begin n_fail++; $display("FAIL b2b_lw rd=%h n=%0d exp=cafef00d/1", o.rdata, o.n_resp); end
  endtask

  task automatic test_random;
    obs_t o;
    bit we, bad;
    logic [2:0] t;
    logic [31:0] a, wd, rd, exp_rd;
    int dly;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1)); t = 3'($urandom_range(0, 7));
      a = $urandom; wd = $urandom; rd = $urandom; dly = $urandom_range(0, 4);
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz_of(t) - 1);
      run_txn(we, t, a, wd, rd, dly, $urandom_range(0, 1), o);
      bad = m_bad(t, a);
      exp_rd = (bad || we) ? 32'h0 : m_load(t, a, rd);
      n_checks++; if (o.hung || o.n_resp !== 1 || o.mis !== bad || o.err !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_resp hung=%0d n=%0d mis=%b err=%b exp=0/1/%b/0", i, o.hung, o.n_resp, o.mis, o.err, bad); end
      n_checks++; if (o.rdata !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata t=%0d a=%h got=%h exp=%h", i, t, a, o.rdata, exp_rd); end
      n_checks++; if (o.saw !== !bad || o.n_stall !== (bad ? 1 : dly + 2)) begin n_fail++; $display("FAIL rnd%0d_flow saw=%0d st=%0d exp=%0d/%0d", i, o.saw, o.n_stall, !bad, bad ? 1 : dly + 2); end
      if (!bad) begin
        n_checks++; if (o.addr !== (a & ~32'h3) || o.we !== we || o.changed) begin n_fail++; $display("FAIL rnd%0d_bus addr=%h we=%b chg=%0d exp=%h/%b/0", i, o.addr, o.we, o.changed, a & ~32'h3, we); end
        n_checks++; if (o.strb !== (we ? m_strb(t, a) : 4'b0)) begin n_fail++; $display("FAIL rnd%0d_strb got=%b exp=%b", i, o.strb, we ? m_strb(t, a) : 4'b0); end
        if (we) begin
          n_checks++; if (o.wd !== m_wdata(t, wd)) begin n_fail++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o.wd, m_wdata(t, wd)); end
        end
      end
    end
  endtask

  initial begin
    mif.req_valid = 1'b0; mif.req_we = 1'b0; mif.req_type = '0; mif.req_addr = '0;
    mif.req_wdata = '0; mif.flush = 1'b0; mif.bus_ack = 1'b0; mif.bus_rdata = '0;
    test_reset();
    test_lw();
    test_sb();
    test_lb_lbu();
    test_misaligned();
    test_timeout();
    test_flush_drain();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
